// File: rtl/gravsim_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gravsim_pkg
//  Description : Shared types and default widths for the ball descriptor
//                table: ball_t descriptor, scheduler state encoding, and
//                the default coordinate and radius widths.
//  Revision    : 1.0  initial release
// ============================================================================
package gravsim_pkg;

    // Default widths; coordinates match DrawX/DrawY of the VGA controller.
    localparam int COORD_W = 10;
    localparam int RAD_W   = 6;

    // One table entry. A radius of zero marks the slot as disabled.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [RAD_W-1:0]   r;
    } ball_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SWAP    = 2'd2,
        COPY    = 2'd3
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/ball_hit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ball_hit_pipe
//  Description : Two-stage per-pixel hit test against every table entry.
//                Stage 1 registers squared distance, squared radius and the
//                enable per ball; stage 2 compares, ORs and priority-encodes
//                the lowest hitting index.
//  Ports       : Clk, Reset_n       clock, synchronous active-low reset
//                ball_x/ball_y/ball_r  front-bank table (parallel read)
//                DrawX, DrawY       current pixel
//                is_ball, hit_idx   result, 2 cycles after DrawX/DrawY
//  Revision    : 1.0  initial release
// ============================================================================
module ball_hit_pipe #(
    parameter int NUM_BALLS = 8,
    parameter int COORD_W   = 10,
    parameter int RAD_W     = 6
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic [COORD_W-1:0]           ball_x [NUM_BALLS],
    input  logic [COORD_W-1:0]           ball_y [NUM_BALLS],
    input  logic [RAD_W-1:0]             ball_r [NUM_BALLS],
    input  logic [COORD_W-1:0]           DrawX,
    input  logic [COORD_W-1:0]           DrawY,
    output logic                         is_ball,
    output logic [$clog2(NUM_BALLS)-1:0] hit_idx
);

    localparam int IDX_W  = $clog2(NUM_BALLS);
    localparam int DIST_W = 2 * COORD_W + 1;
    localparam int R2_W   = 2 * RAD_W;

    logic [NUM_BALLS-1:0] hit;
    // pick[i] is the lowest hitting index among entries i..NUM_BALLS-1.
    logic [IDX_W-1:0]     pick [NUM_BALLS+1];

    assign pick[NUM_BALLS] = '0;

    generate
        for (genvar g = 0; g < NUM_BALLS; g++) begin : g_ball
            logic signed [COORD_W:0]  dx;
            logic signed [COORD_W:0]  dy;
            logic signed [DIST_W-1:0] dx_ext;
            logic signed [DIST_W-1:0] dy_ext;
            logic [DIST_W-1:0]        dx_sq;
            logic [DIST_W-1:0]        dy_sq;
            logic [R2_W-1:0]          r_ext;
            logic [DIST_W-1:0]        dist_q;
            logic [R2_W-1:0]          r2_q;
            logic                     en_q;

            assign dx     = $signed({1'b0, DrawX}) - $signed({1'b0, ball_x[g]});
            assign dy     = $signed({1'b0, DrawY}) - $signed({1'b0, ball_y[g]});
            // |dx| < 2^COORD_W, so the square fits below 2^(2*COORD_W) and
            // the sum of two squares fits DIST_W bits without overflow.
            assign dx_ext = {{COORD_W{dx[COORD_W]}}, dx};
            assign dy_ext = {{COORD_W{dy[COORD_W]}}, dy};
            assign dx_sq  = dx_ext * dx_ext;
            assign dy_sq  = dy_ext * dy_ext;
            assign r_ext  = {{RAD_W{1'b0}}, ball_r[g]};

            always_ff @(posedge Clk) begin
                if (!Reset_n) begin
                    dist_q <= '0;
                    r2_q   <= '0;
                    en_q   <= 1'b0;
                end else begin
                    dist_q <= dx_sq + dy_sq;
                    r2_q   <= r_ext * r_ext;
                    en_q   <= (ball_r[g] != '0);
                end
            end

            assign hit[g]  = en_q && ({{(DIST_W-R2_W){1'b0}}, r2_q} >= dist_q);
            assign pick[g] = hit[g] ? IDX_W'(g) : pick[g+1];
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            is_ball <= 1'b0;
            hit_idx <= '0;
        end else begin
            is_ball <= |hit;
            hit_idx <= pick[0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ball_table_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : ball_table_scheduler
//  Description : Double-buffered ball table. Software edits the back bank and
//                commits; banks swap at the next vsync falling edge, then the
//                new front is copied into the back for incremental edits.
//                The per-pixel hit test reads the front bank.
//  Ports       : Clk, Reset_n             clock, synchronous active-low reset
//                wr_req/wr_idx/wr_x/wr_y/wr_r, wr_ready   back-bank write port
//                commit, swap_pending     swap request and its status
//                frame_count              completed swaps (mod 2^16)
//                VGA_VS                   active-low vertical sync
//                DrawX, DrawY, is_ball, hit_idx   pixel query, 2-cycle latency
//  Revision    : 1.0  initial release
// ============================================================================
module ball_table_scheduler
    import gravsim_pkg::sched_state_e;
    import gravsim_pkg::IDLE;
    import gravsim_pkg::PENDING;
    import gravsim_pkg::SWAP;
    import gravsim_pkg::COPY;
#(
    parameter int NUM_BALLS = 8,
    parameter int COORD_W   = gravsim_pkg::COORD_W,
    parameter int RAD_W     = gravsim_pkg::RAD_W
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         wr_req,
    input  logic [$clog2(NUM_BALLS)-1:0] wr_idx,
    input  logic [COORD_W-1:0]           wr_x,
    input  logic [COORD_W-1:0]           wr_y,
    input  logic [RAD_W-1:0]             wr_r,
    output logic                         wr_ready,
    input  logic                         commit,
    output logic                         swap_pending,
    output logic [15:0]                  frame_count,
    input  logic                         VGA_VS,
    input  logic [COORD_W-1:0]           DrawX,
    input  logic [COORD_W-1:0]           DrawY,
    output logic                         is_ball,
    output logic [$clog2(NUM_BALLS)-1:0] hit_idx
);

    localparam int               IDX_W    = $clog2(NUM_BALLS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BALLS - 1);

    sched_state_e     state;
    logic             front_sel;
    logic             back_sel;
    logic [IDX_W-1:0] copy_cnt;
    logic [15:0]      frame_cnt;
    logic             vs_q;
    logic             vs_fall;

    // Two physical banks; front_sel names the one the pixel path reads.
    logic [COORD_W-1:0] bank_x [2][NUM_BALLS];
    logic [COORD_W-1:0] bank_y [2][NUM_BALLS];
    logic [RAD_W-1:0]   bank_r [2][NUM_BALLS];

    logic [COORD_W-1:0] front_x [NUM_BALLS];
    logic [COORD_W-1:0] front_y [NUM_BALLS];
    logic [RAD_W-1:0]   front_r [NUM_BALLS];

    assign back_sel = ~front_sel;
    // vs_q resets high so a sync already low at reset release is not an edge.
    assign vs_fall  = vs_q & ~VGA_VS;

    generate
        for (genvar g = 0; g < NUM_BALLS; g++) begin : g_front
            assign front_x[g] = bank_x[front_sel][g];
            assign front_y[g] = bank_y[front_sel][g];
            assign front_r[g] = bank_r[front_sel][g];
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state     <= IDLE;
            front_sel <= 1'b0;
            copy_cnt  <= '0;
            frame_cnt <= '0;
            vs_q      <= 1'b1;
            bank_x    <= '{default: '0};
            bank_y    <= '{default: '0};
            bank_r    <= '{default: '0};
        end else begin
            vs_q <= VGA_VS;
            case (state)
                IDLE: begin
                    // A write and a commit together: the write is part of
                    // the bank that will be swapped in.
                    if (wr_req) begin
                        bank_x[back_sel][wr_idx] <= wr_x;
                        bank_y[back_sel][wr_idx] <= wr_y;
                        bank_r[back_sel][wr_idx] <= wr_r;
                    end
                    if (commit) begin
                        state <= PENDING;
                    end
                end
                PENDING: begin
                    // Sync edges seen in any other state are simply dropped.
                    if (vs_fall) begin
                        state <= SWAP;
                    end
                end
                SWAP: begin
                    front_sel <= ~front_sel;
                    frame_cnt <= frame_cnt + 16'd1;
                    copy_cnt  <= '0;
                    state     <= COPY;
                end
                COPY: begin
                    // Bring the old front (now back) up to date with the
                    // bank just made visible.
                    bank_x[back_sel][copy_cnt] <= front_x[copy_cnt];
                    bank_y[back_sel][copy_cnt] <= front_y[copy_cnt];
                    bank_r[back_sel][copy_cnt] <= front_r[copy_cnt];
                    copy_cnt <= copy_cnt + IDX_W'(1);
                    if (copy_cnt == LAST_IDX) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wr_ready     = (state == IDLE);
    assign swap_pending = (state == PENDING);
    assign frame_count  = frame_cnt;

    ball_hit_pipe #(
        .NUM_BALLS (NUM_BALLS),
        .COORD_W   (COORD_W),
        .RAD_W     (RAD_W)
    ) u_hit_pipe (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .ball_x  (front_x),
        .ball_y  (front_y),
        .ball_r  (front_r),
        .DrawX   (DrawX),
        .DrawY   (DrawY),
        .is_ball (is_ball),
        .hit_idx (hit_idx)
    );

endmodule
`default_nettype wire

// File: doc/ball_table_scheduler.md
# ball_table_scheduler

Double-buffered ball-descriptor table shared between the NIOS II software writer and the VGA pixel path. Software writes ball positions/radii into the back bank and commits; the block swaps banks only at the next vertical-sync start, so a frame never shows a torn update, then copies the new front bank into the back bank for incremental edits. Per pixel it resolves `is_ball` and the hit index for `color_mapper`. It replaces the per-pixel `is_ball` export from `nios_system`.

## Interface
- `NUM_BALLS`, 8: table entries, a power of two from 2 to 16.
- `COORD_W`, 10: width of the X/Y coordinates, matching DrawX/DrawY.
- `RAD_W`, 6: radius width. A radius of 0 means the slot is disabled.

- `Clk` in 1: 50 MHz system clock.
- `Reset_n` in 1: synchronous, active-low reset.
- `wr_req` in 1: software write request.
- `wr_idx` in log2(NUM_BALLS): target slot.
- `wr_x`, `wr_y` in COORD_W: ball centre.
- `wr_r` in RAD_W: ball radius.
- `wr_ready` out 1: a write is accepted this cycle when `wr_req && wr_ready`.
- `commit` in 1: single-cycle pulse; requests a bank swap at the next vsync.
- `swap_pending` out 1: a commit is waiting for vsync.
- `frame_count` out 16: number of completed swaps, wraps modulo 2^16.
- `VGA_VS` in 1: active-low vertical sync from `VGA_controller`.
- `DrawX`, `DrawY` in COORD_W: current pixel.
- `is_ball` out 1: the pixel lies inside an enabled ball of the front bank.
- `hit_idx` out log2(NUM_BALLS): lowest-index hit ball; 0 when there is no hit.

## Operation
FSM states:
- **IDLE**: `wr_ready`=1.
  - An accepted write updates `back[wr_idx]`.
  - `commit` goes to PENDING. A write and a commit in the same cycle: the write lands first, then the state goes to PENDING.
- **PENDING**: `wr_ready`=0, `swap_pending`=1.
  - Further commits are ignored.
  - On a vsync falling edge (`vs_q`=1, `VGA_VS`=0) go to SWAP.
- **SWAP**: one cycle.
  - Toggle `front_sel` and increment `frame_count`.
  - Go to COPY.
- **COPY**: NUM_BALLS cycles, `wr_ready`=0.
  - Each cycle copies `front[i]` to `back[i]` for i = 0..NUM_BALLS-1, using a copy counter.
  - After the last entry go to IDLE.

Edge detection: `vs_q` is VGA_VS registered on Clk.
- Reset value 1, so a low VGA_VS at reset release does not count as an edge.
- An edge that arrives outside PENDING is dropped, not queued.

Pixel path: a 2-stage pipeline against the front bank, which is stable except at the SWAP cycle.
- **Stage 1** registers, per ball:
  - dx = DrawX − x and dy = DrawY − y, signed COORD_W+1;
  - dx² + dy², 2·COORD_W+1 bits unsigned;
  - r², 2·RAD_W bits;
  - enable = (r ≠ 0).
- **Stage 2**:
  - hit_i = enable_i && (dist² ≤ r², zero-extended);
  - `is_ball` = OR of all hit_i;
  - `hit_idx` = lowest i with hit_i set, registered.

Reset (any state, including mid-COPY or PENDING):
- state=IDLE; both banks zeroed, so all slots are disabled; `front_sel`=0.
- `frame_count`=0, `swap_pending`=0.
- Pipeline registers cleared, so `is_ball`=0 and `hit_idx`=0.
- `wr_ready` reads 1 from the first cycle after reset deasserts.

## Timing
- Write: an accepted write is visible in the back bank on the next edge. It reaches the screen only after commit → vsync → SWAP.
- Commit to swap: vsync falling edge at cycle t (VGA_VS sampled low) → SWAP at t+1 → `front_sel` and `frame_count` update at the end of t+1 → COPY over t+2 … t+1+NUM_BALLS → IDLE (`wr_ready`=1) at t+2+NUM_BALLS.
- Pixel latency: exactly 2 Clk cycles from DrawX/DrawY to `is_ball`/`hit_idx`. The downstream colour path compensates.
- The swap occurs at the start of vsync, well inside vertical blanking, so pixels in flight are never visible.
- The worst case of 10 cycles for NUM_BALLS=8 is far below the blanking interval.

## Structure
- `gravsim_pkg` holds:
  - `ball_t` struct {x, y, r};
  - `sched_state_e` enum {IDLE, PENDING, SWAP, COPY};
  - the default constants COORD_W and RAD_W.
- Sub-module `ball_hit_pipe`: the 2-stage distance/compare/priority pipeline. Inputs are the front-bank array and DrawX/DrawY; outputs are `is_ball` and `hit_idx`.
- The banks are flop arrays, since they need parallel read for the pixel path. No RAM inference.

## Test plan
- **Reset:** hold Reset_n=0 with random inputs. Require `is_ball`=0, `hit_idx`=0, `frame_count`=0, `swap_pending`=0; `wr_ready`=1 one cycle after release.
- **Write/commit/swap:** write slot 2 = (100,100,r=5), commit, pulse VGA_VS low. Require `swap_pending` high until the edge, `frame_count`=1, and `wr_ready` low for exactly 1+NUM_BALLS cycles after the edge. Then DrawX/Y=(103,104) → `is_ball`=1, `hit_idx`=2 two cycles later; (104,104) → `is_ball`=0.
- **No tearing:** write and commit, then drive pixels inside the new ball before vsync. Require `is_ball`=0 until the swap.
- **Priority:** overlapping slots 1 and 5, both covering (50,50). Require `hit_idx`=1.
- **Rejection:** in PENDING and COPY, `wr_req` and `commit` are ignored (`wr_ready`=0, back bank unchanged). Write and commit in the same IDLE cycle: the write is included in the swap.
- **Wrap and mid-op reset:** preload `frame_count`=0xFFFF via 65535 swaps (or force) → the next swap gives 0x0000. Assert Reset_n during COPY → IDLE with all slots disabled.
